scan_sequencer_4lane: RTL and testbench

- Sequential front end for the team's 2-to-4 decoder.
- Cycles a 2-bit lane index `sel` plus a decoder enable `sel_en` through up to four lanes: digit/row multiplexing, round-robin chip select.
- Each lane is held for a programmable dwell time.
- An optional blanking gap with the enable low separates lanes, so decoder outputs never overlap.
- Lanes cleared in `lane_mask` are skipped. A one-cycle `frame_done` pulse marks each completed scan.

---
 rtl/scan_sequencer_4lane_pkg.sv | 11 +
 rtl/scan_sequencer_4lane_next_lane_pick.sv | 27 ++
 rtl/scan_sequencer_4lane.sv | 142 ++++++++++++++
 tb/tb_scan_sequencer_4lane.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_4lane_pkg.sv
// Shared constants and FSM state type for the 4-lane scan sequencer.
package scan_pkg;
  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;
endpackage

// File: rtl/scan_sequencer_4lane_next_lane_pick.sv
// Combinational lane picker: next enabled lane strictly after cur, wrapping.
// With cur = LANES-1 it yields the lowest enabled lane (first-lane pick).
module next_lane_pick
  import scan_pkg::*;
(
  input  logic [LANES-1:0] lane_mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);

  logic [SEL_W-1:0] w_idx;

  // Rotate-and-priority search; scanning farthest-first lets the nearest hit win.
  always_comb begin
    nxt   = cur;
    w_idx = '0;
    for (int unsigned i = LANES; i >= 1; i--) begin
      w_idx = cur + SEL_W'(i);
      if (lane_mask[w_idx]) nxt = w_idx;
    end
    none = ~|lane_mask;
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/scan_sequencer_4lane.sv
// Round-robin lane scanner driving a 2-to-4 decoder: per-lane blanking gap,
// programmable dwell, lane skipping and an end-of-frame pulse.
module scan_sequencer_4lane
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  input  logic [LANES-1:0]   lane_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               frame_done
);

  localparam int unsigned CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_sel_en;
  logic             r_frame_done;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_en;
  logic             w_frame_done;

  logic [SEL_W-1:0] w_pick_cur;
  logic [SEL_W-1:0] w_pick_nxt;
  logic             w_pick_wrap;
  logic             w_pick_none;
  logic [CNT_W-1:0] w_blank_load;
  logic [CNT_W-1:0] w_dwell_load;
  logic             w_blank_nz;

  // Outside DRIVE the picker searches from the top lane, giving the lowest set bit.
  assign w_pick_cur   = (r_state == DRIVE) ? r_sel : SEL_W'(LANES - 1);
  assign w_blank_nz   = |blank;
  assign w_blank_load = CNT_W'(blank - BLANK_W'(1));
  assign w_dwell_load = CNT_W'(dwell);

  next_lane_pick u_pick (
    .lane_mask (lane_mask),
    .cur       (w_pick_cur),
    .nxt       (w_pick_nxt),
    .wrap      (w_pick_wrap),
    .none      (w_pick_none)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_sel_en     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_sel        <= w_sel;
      r_sel_en     <= w_sel_en;
      r_frame_done <= w_frame_done;
    end
  end

  // Next-state, counter and output values; abort overrides everything.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_sel        = r_sel;
    w_sel_en     = r_sel_en;
    w_frame_done = 1'b0;
    if (!run) begin
      w_state  = IDLE;
      w_sel_en = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sel_en = 1'b0;
          if (!w_pick_none) begin
            w_sel = w_pick_nxt;
            if (w_blank_nz) begin
              w_state = BLANK;
              w_cnt   = w_blank_load;
            end else begin
              w_state  = DRIVE;
              w_cnt    = w_dwell_load;
              w_sel_en = 1'b1;
            end
          end
        end
        BLANK: begin
          if (r_cnt == '0) begin
            w_state  = DRIVE;
            w_cnt    = w_dwell_load;
            w_sel_en = 1'b1;
          end else begin
            w_cnt = r_cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            if (w_pick_none) begin
              w_state  = IDLE;
              w_sel_en = 1'b0;
            end else begin
              w_sel        = w_pick_nxt;
              w_frame_done = w_pick_wrap;
              if (w_blank_nz) begin
                w_state  = BLANK;
                w_cnt    = w_blank_load;
                w_sel_en = 1'b0;
              end else begin
                w_state  = DRIVE;
                w_cnt    = w_dwell_load;
                w_sel_en = 1'b1;
              end
            end
          end else begin
            w_cnt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state  = IDLE;
          w_sel_en = 1'b0;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign sel_en     = r_sel_en;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_sequencer_4lane.sv
// Bench for scan_sequencer_4lane: phase-count reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_scan_sequencer_4lane;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] dwell;
  logic [7:0]  blank;
  logic [3:0]  lane_mask;
  logic [1:0]  sel;
  logic        sel_en;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  scan_sequencer_4lane #(.DWELL_W(16), .BLANK_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .dwell      (dwell),
    .blank      (blank),
    .lane_mask  (lane_mask),
    .sel        (sel),
    .sel_en     (sel_en),
    .frame_done (frame_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining blank cycles / remaining drive cycles per lane.
  bit m_active = 0;
  int m_sel    = 0;
  int m_bl     = 0;
  int m_dl     = 0;
  bit m_fd     = 0;

  function automatic int next_lane(input logic [3:0] mask, input int cur);
    for (int k = 1; k <= 4; k++) begin
      int l;
      l = (cur + k) % 4;
      if (mask[l]) return l;
    end
    return -1;
  endfunction

  task automatic start_lane(input int l);
    m_sel    = l;
    m_active = 1;
    if (blank != 0) begin
      m_bl = blank;
      m_dl = 0;
    end else begin
      m_bl = 0;
      m_dl = dwell + 1;
    end
  endtask

  always @(posedge clk) begin
    int n;
    m_fd = 0;
    if (!rst_n) begin
      m_active = 0;
      m_sel    = 0;
      m_bl     = 0;
      m_dl     = 0;
    end else if (!run) begin
      m_active = 0;
    end else if (!m_active) begin
      if (lane_mask != 0) start_lane(next_lane(lane_mask, 3));
    end else if (m_bl > 0) begin
      if (m_bl > 1) m_bl--;
      else begin
        m_bl = 0;
        m_dl = dwell + 1;
      end
    end else if (m_dl > 1) begin
      m_dl--;
    end else begin
      n = next_lane(lane_mask, m_sel);
      if (n < 0) m_active = 0;
      else begin
        m_fd = (n <= m_sel);
        start_lane(n);
      end
    end
  end

  // Single compare process: every cycle once checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sel", sel, m_sel);
      chk("sel_en", sel_en, (m_active && m_bl == 0) ? 1 : 0);
      chk("frame_done", frame_done, m_fd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_window(input int n, output int ones, output int fds);
    ones = 0;
    fds  = 0;
    repeat (n) begin
      @(negedge clk);
      ones += sel_en;
      fds  += frame_done;
    end
  endtask

  task automatic wait_lane(input int lane, input bit en);
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (sel == lane && sel_en == en) found = 1;
    end
    chk("wait_lane_timeout", found, 1);
  endtask

  initial begin
    int ones, fds;
    rst_n = 0; run = 0; lane_mask = 0; dwell = 0; blank = 0;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("reset_sel", sel, 0);
    chk("reset_sel_en", sel_en, 0);
    chk("reset_frame_done", frame_done, 0);
    rst_n = 1;

    // Full scan: 4 lanes x (1 blank + 3 drive) = 16-cycle frame.
    lane_mask = 4'b1111; dwell = 2; blank = 1; run = 1;
    repeat (6) tick();
    count_window(48, ones, fds);
    chk("full_scan_en_cycles", ones, 36);
    chk("full_scan_frames", fds, 3);

    // Lane skip: lanes 1,3, one cycle each, no gap.
    lane_mask = 4'b1010; dwell = 0; blank = 0;
    repeat (20) tick();
    count_window(20, ones, fds);
    chk("skip_en_cycles", ones, 20);
    chk("skip_frames", fds, 10);

    // Single lane: pattern 0,0,1,1,1,1.
    lane_mask = 4'b0100; dwell = 3; blank = 2;
    repeat (20) tick();
    count_window(24, ones, fds);
    chk("single_en_cycles", ones, 16);
    chk("single_frames", fds, 4);
    chk("single_sel", sel, 2);

    // Abort mid-DRIVE of lane 1, then restart.
    lane_mask = 4'b1111; dwell = 5; blank = 1;
    wait_lane(1, 1);
    run = 0;
    tick();
    @(negedge clk);
    chk("abort_sel_en", sel_en, 0);
    chk("abort_frame_done", frame_done, 0);
    run = 1;
    wait_lane(0, 1);

    // Synchronous reset for one edge during lane 2 blanking.
    blank = 3; dwell = 2;
    wait_lane(2, 0);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("midreset_sel", sel, 0);
    chk("midreset_sel_en", sel_en, 0);
    chk("midreset_frame_done", frame_done, 0);
    // Glitch between edges is never sampled.
    tick();
    rst_n = 0;
    #1 rst_n = 1;
    wait_lane(0, 1);

    // Mask cleared during lane 2 drive.
    dwell = 4; blank = 1;
    wait_lane(2, 1);
    lane_mask = 4'b0000;
    repeat (12) tick();
    @(negedge clk);
    chk("mask0_sel_en", sel_en, 0);
    chk("mask0_sel", sel, 2);

    // Randomized stimulus against the model.
    lane_mask = 4'b1111;
    run = 1;
    repeat (1500) begin
      tick();
      if (run) run = ($urandom_range(0, 39) != 0);
      else     run = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) lane_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)  dwell = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  blank = 8'($urandom_range(0, 2));
      rst_n = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1;
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
